// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg -- shared PS/2 Set-2 definitions for the ASCII-to-keystroke path.
//   PS2_BREAK / PS2_LSHIFT : break prefix and left-shift make code
//   state_t                : keystroke transmitter FSM states
//   SEQ_*_LEN              : byte counts of plain and shifted keystrokes
//   seq_byte()             : byte at a given position of a keystroke
//   seq_last_idx()         : index of the final byte of a keystroke
// ---------------------------------------------------------------------------
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  localparam logic [7:0] PS2_LSHIFT = 8'h12;

  localparam int SEQ_PLAIN_LEN = 3;
  localparam int SEQ_SHIFT_LEN = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  // plain   : M, F0, M
  // shifted : 12, M, F0, M, F0, 12
  function automatic logic [7:0] seq_byte(input logic [2:0] idx,
                                          input logic [7:0] make,
                                          input logic       shift);
    logic [7:0] b;
    b = make;
    if (!shift) begin
      case (idx)
        3'd1:    b = PS2_BREAK;
        default: b = make;
      endcase
    end else begin
      case (idx)
        3'd0:    b = PS2_LSHIFT;
        3'd2:    b = PS2_BREAK;
        3'd4:    b = PS2_BREAK;
        3'd5:    b = PS2_LSHIFT;
        default: b = make;
      endcase
    end
    return b;
  endfunction

  function automatic logic [2:0] seq_last_idx(input logic shift);
    return shift ? 3'(SEQ_SHIFT_LEN - 1) : 3'(SEQ_PLAIN_LEN - 1);
  endfunction

endpackage

// File: rtl/ascii2key_tx_if.sv
// ---------------------------------------------------------------------------
// ascii2key_tx_if -- character-in / scan-byte-out handshake bundle.
//   in_valid, in_ascii  : ASCII character offered by the text/menu logic
//   in_ready            : transmitter can take a character
//   out_valid, out_byte : Set-2 scan byte offered downstream
//   out_ready           : downstream takes the byte
//   busy                : keystroke sequence in progress
//   err                 : one-cycle pulse, accepted character had no mapping
// master = character source / byte sink, slave = the transmitter.
// ---------------------------------------------------------------------------
interface ascii2key_tx_if;
  logic       in_valid;
  logic [7:0] in_ascii;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_byte;
  logic       out_ready;
  logic       busy;
  logic       err;

  modport master (
    output in_valid, in_ascii, out_ready,
    input  in_ready, out_valid, out_byte, busy, err
  );

  modport slave (
    input  in_valid, in_ascii, out_ready,
    output in_ready, out_valid, out_byte, busy, err
  );
endinterface

// File: rtl/ascii2key_lut.sv
// ---------------------------------------------------------------------------
// ascii2key_lut -- combinational ASCII to PS/2 Set-2 make-code lookup,
// the inverse of the scan-code-to-ASCII decoder table.
//   ascii : ASCII code
//   make  : Set-2 make code (0 when unmapped)
//   shift : character needs left shift (uppercase A..Z)
//   valid : character has a mapping
// ---------------------------------------------------------------------------
module ascii2key_lut (
  input  logic [7:0] ascii,
  output logic [7:0] make,
  output logic       shift,
  output logic       valid
);

  logic [7:0] key;

  // NOTE: every output of a combinational block gets a default before the
  // case, otherwise unlisted codes would make synthesis infer latches.
  always_comb begin
    shift = (ascii >= 8'h41) && (ascii <= 8'h5A);
    // Uppercase reuses the lowercase make code.
    key   = shift ? (ascii | 8'h20) : ascii;
    make  = 8'h00;
    case (key)
      8'h61: make = 8'h1C; 8'h62: make = 8'h32; 8'h63: make = 8'h21;
      8'h64: make = 8'h23; 8'h65: make = 8'h24; 8'h66: make = 8'h2B;
      8'h67: make = 8'h34; 8'h68: make = 8'h33; 8'h69: make = 8'h43;
      8'h6A: make = 8'h3B; 8'h6B: make = 8'h42; 8'h6C: make = 8'h4B;
      8'h6D: make = 8'h3A; 8'h6E: make = 8'h31; 8'h6F: make = 8'h44;
      8'h70: make = 8'h4D; 8'h71: make = 8'h15; 8'h72: make = 8'h2D;
      8'h73: make = 8'h1B; 8'h74: make = 8'h2C; 8'h75: make = 8'h3C;
      8'h76: make = 8'h2A; 8'h77: make = 8'h1D; 8'h78: make = 8'h22;
      8'h79: make = 8'h35; 8'h7A: make = 8'h1A;
      8'h30: make = 8'h45; 8'h31: make = 8'h16; 8'h32: make = 8'h1E;
      8'h33: make = 8'h26; 8'h34: make = 8'h25; 8'h35: make = 8'h2E;
      8'h36: make = 8'h36; 8'h37: make = 8'h3D; 8'h38: make = 8'h3E;
      8'h39: make = 8'h46;
      8'h60: make = 8'h0E; // `
      8'h2D: make = 8'h4E; // -
      8'h3D: make = 8'h55; // =
      8'h5B: make = 8'h54; // [
      8'h5D: make = 8'h5B; // ]
      8'h5C: make = 8'h5D; // backslash
      8'h3B: make = 8'h4C; // ;
      8'h27: make = 8'h52; // '
      8'h2C: make = 8'h41; // ,
      8'h2E: make = 8'h49; // .
      8'h2F: make = 8'h4A; // /
      8'h20: make = 8'h29; // space
      8'h0D: make = 8'h5A; // Enter
      8'h08: make = 8'h66; // Backspace
      8'h09: make = 8'h0D; // Tab
      default: make = 8'h00;
    endcase
    // No real make code is 0x00, so it doubles as the "unmapped" marker.
    valid = (make != 8'h00);
  end

endmodule

// File: rtl/ascii2key_tx.sv
// ---------------------------------------------------------------------------
// ascii2key_tx -- accepts one ASCII character per handshake and emits the
// PS/2 Set-2 byte stream of a full keystroke (make then break), wrapping
// uppercase letters in left-shift make/break.
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : ascii2key_tx_if slave (character in, scan bytes out,
//              busy, err)
// BYTE_GAP idle cycles separate consecutive bytes of one keystroke.
// ---------------------------------------------------------------------------
module ascii2key_tx
  import ps2_pkg::*;
#(
  parameter int BYTE_GAP = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  ascii2key_tx_if.slave bus
);

  // A zero-width counter is illegal, so BYTE_GAP=0 keeps one unused bit.
  localparam int GAP_W = (BYTE_GAP > 0) ? $clog2(BYTE_GAP + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST =
    (BYTE_GAP > 0) ? GAP_W'(BYTE_GAP - 1) : '0;

  state_t           state_q, state_d;
  logic [2:0]       idx_q;
  logic [GAP_W-1:0] gap_q;
  logic [7:0]       make_q;
  logic             shift_q;
  logic             err_q;

  logic [7:0]       lut_make;
  logic             lut_shift;
  logic             lut_valid;

  logic             ready;
  logic             accept;
  logic             handshake;
  logic             last_byte;
  logic             gap_done;
  logic [2:0]       idx_next;

  ascii2key_lut u_lut (
    .ascii (bus.in_ascii),
    .make  (lut_make),
    .shift (lut_shift),
    .valid (lut_valid)
  );

  // reset_n gates ready directly so the source sees 0 throughout reset.
  assign ready     = reset_n && (state_q == IDLE);
  assign accept    = bus.in_valid && ready;
  assign handshake = (state_q == SEND) && bus.out_ready;
  assign last_byte = (idx_q == seq_last_idx(shift_q));
  assign gap_done  = (gap_q == GAP_LAST);
  assign idx_next  = last_byte ? idx_q : idx_q + 3'd1;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && lut_valid) state_d = SEND;
      SEND: begin
        if (handshake) begin
          if (last_byte)          state_d = IDLE;
          else if (BYTE_GAP == 0) state_d = SEND;
          else                    state_d = GAP;
        end
      end
      GAP:     if (gap_done) state_d = SEND;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latched character, byte index, gap counter, error pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q   <= 3'd0;
      gap_q   <= '0;
      make_q  <= 8'h00;
      shift_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= accept && !lut_valid;
      case (state_q)
        IDLE: begin
          if (accept && lut_valid) begin
            make_q  <= lut_make;
            shift_q <= lut_shift;
            idx_q   <= 3'd0;
          end
        end
        SEND: begin
          if (handshake && !last_byte) begin
            if (BYTE_GAP == 0) idx_q <= idx_next;
            else               gap_q <= '0;
          end
        end
        GAP: begin
          if (gap_done) begin
            idx_q <= idx_next;
            gap_q <= '0;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are decoded from registered state, so out_valid and out_byte
  // hold steady while the downstream stalls and drop with reset.
  always_comb begin
    bus.in_ready  = ready;
    bus.out_valid = (state_q == SEND);
    bus.out_byte  = (state_q == SEND) ? seq_byte(idx_q, make_q, shift_q)
                                      : 8'h00;
    bus.busy      = (state_q != IDLE);
    bus.err       = err_q;
  end

endmodule

// File: tb/tb_ascii2key_tx.sv
module tb_ascii2key_tx;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [7:0] mon0_b[$];
  int         mon0_c[$];
  logic [7:0] mon1_b[$];
  int         mon1_c[$];

  ascii2key_tx_if bus0 ();
  ascii2key_tx_if bus1 ();

  ascii2key_tx #(.BYTE_GAP(0)) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));
  ascii2key_tx #(.BYTE_GAP(4)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every byte handshake (sampled mid-cycle, completes at next edge).
  always @(negedge clk) begin
    if (reset_n && bus0.out_valid && bus0.out_ready) begin
      mon0_b.push_back(bus0.out_byte);
      mon0_c.push_back(cyc);
    end
    if (reset_n && bus1.out_valid && bus1.out_ready) begin
      mon1_b.push_back(bus1.out_byte);
      mon1_c.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer c to dut0 until accepted; returns just after the accept edge.
  task automatic accept0(input logic [7:0] c);
    int t = 0;
    bus0.in_valid = 1'b1;
    bus0.in_ascii = c;
    while (!bus0.in_ready && t < 50) begin step(); t++; end
    if (!bus0.in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL accept0_timeout: char %h never accepted", c);
    end
    step();
    bus0.in_valid = 1'b0;
  endtask

  task automatic accept1(input logic [7:0] c);
    int t = 0;
    bus1.in_valid = 1'b1;
    bus1.in_ascii = c;
    while (!bus1.in_ready && t < 50) begin step(); t++; end
    if (!bus1.in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL accept1_timeout: char %h never accepted", c);
    end
    step();
    bus1.in_valid = 1'b0;
  endtask

  task automatic wait_bytes0(input int n);
    int t = 0;
    while (mon0_b.size() < n && t < 100) begin step(); t++; end
    if (mon0_b.size() < n) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_bytes0_timeout: got %0d bytes, expected %0d", mon0_b.size(), n);
    end
  endtask

  task automatic test_reset();
    bus0.in_valid = 0; bus0.in_ascii = 0; bus0.out_ready = 0;
    bus1.in_valid = 0; bus1.in_ascii = 0; bus1.out_ready = 0;
    repeat (2) step();
    n_cmp++;
    if ({bus0.in_ready, bus0.out_valid, bus0.out_byte, bus0.busy, bus0.err} !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_dut0: rdy/vld/byte/busy/err got %b %b %h %b %b expected 0 0 00 0 0",
               bus0.in_ready, bus0.out_valid, bus0.out_byte, bus0.busy, bus0.err);
    end
    n_cmp++;
    if ({bus1.in_ready, bus1.out_valid, bus1.out_byte, bus1.busy, bus1.err} !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_dut1: rdy/vld/byte/busy/err got %b %b %h %b %b expected 0 0 00 0 0",
               bus1.in_ready, bus1.out_valid, bus1.out_byte, bus1.busy, bus1.err);
    end
    @(posedge clk); #3 reset_n = 1'b1;
    step();
    n_cmp++;
    if (bus0.in_ready !== 1'b1 || bus1.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release_ready: got %b %b expected 1 1", bus0.in_ready, bus1.in_ready);
    end
  endtask

  task automatic test_plain_a();
    logic [7:0] exp [3] = '{8'h1C, 8'hF0, 8'h1C};
    bus0.out_ready = 1'b1;
    accept0(8'h61);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (bus0.out_valid !== 1'b1 || bus0.out_byte !== exp[i] || bus0.busy !== 1'b1) begin
        n_bad++;
        $display("FAIL plain_a_byte%0d: vld/byte/busy got %b %h %b expected 1 %h 1",
                 i, bus0.out_valid, bus0.out_byte, bus0.busy, exp[i]);
      end
      step();
    end
    n_cmp++;
    if (bus0.busy !== 1'b0 || bus0.in_ready !== 1'b1 || bus0.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL plain_a_done: busy/rdy/vld got %b %b %b expected 0 1 0",
               bus0.busy, bus0.in_ready, bus0.out_valid);
    end
  endtask

  task automatic test_shift_gap();
    logic [7:0] exp [6] = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12};
    int t = 0;
    int rdy_bad = 0;
    mon1_b.delete(); mon1_c.delete();
    bus1.out_ready = 1'b1;
    accept1(8'h41);
    while (bus1.busy === 1'b1 && t < 60) begin
      if (bus1.in_ready !== 1'b0) rdy_bad++;
      step(); t++;
    end
    n_cmp++;
    if (rdy_bad != 0 || t >= 60) begin
      n_bad++;
      $display("FAIL shift_gap_ready: in_ready high %0d cycles, loop %0d, expected 0 and done",
               rdy_bad, t);
    end
    n_cmp++;
    if (mon1_b.size() != 6) begin
      n_bad++;
      $display("FAIL shift_gap_count: got %0d bytes expected 6", mon1_b.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++;
        if (mon1_b[i] !== exp[i]) begin
          n_bad++;
          $display("FAIL shift_gap_byte%0d: got %h expected %h", i, mon1_b[i], exp[i]);
        end
        if (i > 0) begin
          n_cmp++;
          if (mon1_c[i] - mon1_c[i-1] != 5) begin
            n_bad++;
            $display("FAIL shift_gap_spacing%0d: got %0d expected 5", i, mon1_c[i] - mon1_c[i-1]);
          end
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0] exp [3] = '{8'h2E, 8'hF0, 8'h2E};
    mon0_b.delete(); mon0_c.delete();
    bus0.out_ready = 1'b0;
    accept0(8'h35);
    for (int i = 0; i < 7; i++) begin
      n_cmp++;
      if (bus0.out_valid !== 1'b1 || bus0.out_byte !== 8'h2E) begin
        n_bad++;
        $display("FAIL stall_hold%0d: vld/byte got %b %h expected 1 2e",
                 i, bus0.out_valid, bus0.out_byte);
      end
      step();
    end
    bus0.out_ready = 1'b1;
    wait_bytes0(3);
    repeat (3) step();
    n_cmp++;
    if (mon0_b.size() != 3) begin
      n_bad++;
      $display("FAIL stall_count: got %0d bytes expected 3", mon0_b.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (mon0_b[i] !== exp[i]) begin
          n_bad++;
          $display("FAIL stall_byte%0d: got %h expected %h", i, mon0_b[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_unmapped();
    logic [7:0] exp [3] = '{8'h5A, 8'hF0, 8'h5A};
    mon0_b.delete(); mon0_c.delete();
    bus0.out_ready = 1'b1;
    n_cmp++;
    if (bus0.err !== 1'b0) begin
      n_bad++;
      $display("FAIL unmapped_err_before: got %b expected 0", bus0.err);
    end
    accept0(8'h7E);
    n_cmp++;
    if (bus0.err !== 1'b1 || bus0.out_valid !== 1'b0 || bus0.busy !== 1'b0 || bus0.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL unmapped_pulse: err/vld/busy/rdy got %b %b %b %b expected 1 0 0 1",
               bus0.err, bus0.out_valid, bus0.busy, bus0.in_ready);
    end
    step();
    n_cmp++;
    if (bus0.err !== 1'b0) begin
      n_bad++;
      $display("FAIL unmapped_pulse_width: err got %b expected 0", bus0.err);
    end
    repeat (3) step();
    n_cmp++;
    if (mon0_b.size() != 0) begin
      n_bad++;
      $display("FAIL unmapped_no_bytes: got %0d bytes expected 0", mon0_b.size());
    end
    accept0(8'h0D);
    wait_bytes0(3);
    repeat (2) step();
    n_cmp++;
    if (mon0_b.size() != 3) begin
      n_bad++;
      $display("FAIL enter_count: got %0d bytes expected 3", mon0_b.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (mon0_b[i] !== exp[i]) begin
          n_bad++;
          $display("FAIL enter_byte%0d: got %h expected %h", i, mon0_b[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [6] = '{8'h0D, 8'hF0, 8'h0D, 8'h66, 8'hF0, 8'h66};
    int exp_gap [6] = '{0, 1, 1, 2, 1, 1};
    int t = 0;
    mon0_b.delete(); mon0_c.delete();
    bus0.out_ready = 1'b1;
    bus0.in_valid  = 1'b1;
    bus0.in_ascii  = 8'h09;
    while (!bus0.in_ready && t < 20) begin step(); t++; end
    step();
    bus0.in_ascii = 8'h08;
    t = 0;
    while (!bus0.in_ready && t < 20) begin step(); t++; end
    step();
    bus0.in_valid = 1'b0;
    wait_bytes0(6);
    repeat (2) step();
    n_cmp++;
    if (mon0_b.size() != 6) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d bytes expected 6", mon0_b.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++;
        if (mon0_b[i] !== exp[i]) begin
          n_bad++;
          $display("FAIL b2b_byte%0d: got %h expected %h", i, mon0_b[i], exp[i]);
        end
        if (i > 0) begin
          n_cmp++;
          if (mon0_c[i] - mon0_c[i-1] != exp_gap[i]) begin
            n_bad++;
            $display("FAIL b2b_spacing%0d: got %0d expected %0d",
                     i, mon0_c[i] - mon0_c[i-1], exp_gap[i]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp [3] = '{8'h1A, 8'hF0, 8'h1A};
    mon0_b.delete(); mon0_c.delete();
    bus0.out_ready = 1'b1;
    accept0(8'h5A);
    step();
    n_cmp++;
    if (bus0.out_valid !== 1'b1 || bus0.out_byte !== 8'h1A) begin
      n_bad++;
      $display("FAIL rst_mid_byte2: vld/byte got %b %h expected 1 1a", bus0.out_valid, bus0.out_byte);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (bus0.out_valid !== 1'b0 || bus0.busy !== 1'b0 || bus0.in_ready !== 1'b0 || bus0.out_byte !== 8'h00) begin
      n_bad++;
      $display("FAIL rst_mid_async: vld/busy/rdy/byte got %b %b %b %h expected 0 0 0 00",
               bus0.out_valid, bus0.busy, bus0.in_ready, bus0.out_byte);
    end
    @(posedge clk); #3 reset_n = 1'b1;
    step();
    n_cmp++;
    if (bus0.in_ready !== 1'b1 || bus0.busy !== 1'b0 || bus0.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_release: rdy/busy/vld got %b %b %b expected 1 0 0",
               bus0.in_ready, bus0.busy, bus0.out_valid);
    end
    n_cmp++;
    if (mon0_b.size() != 1 || mon0_b[0] !== 8'h12) begin
      n_bad++;
      $display("FAIL rst_mid_partial: got %0d bytes (first %h) expected 1 byte 12",
               mon0_b.size(), (mon0_b.size() > 0) ? mon0_b[0] : 8'h00);
    end
    mon0_b.delete(); mon0_c.delete();
    accept0(8'h7A);
    wait_bytes0(3);
    repeat (2) step();
    n_cmp++;
    if (mon0_b.size() != 3) begin
      n_bad++;
      $display("FAIL rst_mid_z_count: got %0d bytes expected 3", mon0_b.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (mon0_b[i] !== exp[i]) begin
          n_bad++;
          $display("FAIL rst_mid_z_byte%0d: got %h expected %h", i, mon0_b[i], exp[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_plain_a();
    test_shift_gap();
    test_stall();
    test_unmapped();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
